rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-way round-robin arbiter that shares one resource between eight requesters and drives the resource's one-hot select lines from a 3-bit granted index. It sits in front of the 3-to-8 decode stage and sequences which requester owns the shared path. It supports variable-length ownership, voluntary release and a forced timeout. Grants are registered, one-hot and glitch-free, with one turnaround cycle between owners.

## Interface

**Parameters**

- `MAX_HOLD`, default 16: maximum consecutive grant cycles before forced release. 0 disables the timeout. Legal range is 0..255.

**Ports**

- `clk`  input  1  — single clock; all logic on its rising edge.
- `rst_n`  input  1  — synchronous, active-low reset, sampled on the rising edge of `clk`.
- `en`  input  1  — arbitration enable. When low, no new grant is issued.
- `req`  input  8  — request vector; bit i is requester i. Level-sensitive.
- `done`  input  1  — release strobe from the current owner. Ignored when `gnt_valid` is 0.
- `gnt`  output  8  — one-hot grant, equal to the decode of `gnt_id` when `gnt_valid` is 1, else all zeros.
- `gnt_id`  output  3  — binary index of the current owner. Holds its last value when idle.
- `gnt_valid`  output  1  — a grant is active.
- `timeout`  output  1  — single-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation

**Reset**

- `gnt` = 8'h00, `gnt_id` = 3'd0, `gnt_valid` = 0, `timeout` = 0.
- Priority pointer `ptr` = 3'd0, hold counter = 0, state = IDLE.

**State machine:** two states, IDLE and GRANT.

**IDLE**

- If `en` = 1 and `req` != 0: select the first set bit of `req`, scanning circularly from `ptr` upward (`ptr`, `ptr`+1, … wrapping 7→0).
- Register that index into `gnt_id`, set `gnt_valid` = 1, load hold counter = 1, go to GRANT.
- Otherwise remain in IDLE with all outputs unchanged, `gnt` = 0.

**GRANT:** release occurs when any of the following holds:

- `done` = 1.
- `req[gnt_id]` = 0 (the owner dropped its request).
- `MAX_HOLD` != 0 and hold counter == `MAX_HOLD`.

**On release**

- Next cycle: `gnt_valid` = 0, `gnt` = 0, state = IDLE.
- `ptr` = (`gnt_id` + 1) mod 8.

**Timeout**

- `timeout` pulses for one cycle, coincident with the cycle `gnt_valid` falls, only when the release was caused solely by the hold limit.
- If `done` or the request drop coincides with the hold limit, the release counts as voluntary and `timeout` stays 0.

**Hold counter**

- Otherwise, in GRANT without release, the hold counter increments.
- Width is 8 bits, saturating; it never wraps.

**Enable**

- `en` only gates new grants in IDLE.
- A grant in progress is unaffected by `en` falling and completes normally.

**Other rules**

- Requests from non-owners during GRANT are ignored; there is no preemption.
- `ptr` advances only on release, never on idle cycles.

## Timing

- Grant latency: `req` sampled high in IDLE at edge N gives `gnt`/`gnt_valid` high after edge N, visible in cycle N+1.
- Release latency: release condition sampled at edge M gives `gnt` = 0 in cycle M+1. The earliest next grant appears in cycle M+2, which is the mandatory one-cycle turnaround.
- With `MAX_HOLD` = H and no voluntary release, `gnt` stays high for exactly H cycles; `timeout` is high in the following cycle.
- `gnt`, `gnt_id`, `gnt_valid` and `timeout` are all registered outputs with no combinational path from inputs.
- `gnt` never has more than one bit set and never changes owner without an all-zero cycle in between.
- Reset mid-grant: `rst_n` low at any edge forces the full reset state in the next cycle, with `ptr` back to 0. This overrides `done` and timeout in the same cycle, and no `timeout` pulse is generated.

## Test plan

- **Reset:** hold `rst_n` = 0 for 2 cycles with `req` = 8'hFF → `gnt` = 8'h00, `gnt_valid` = 0, `gnt_id` = 0 throughout. After release of reset, `gnt` = 8'h01 one cycle later.
- **Single requester:** `req` = 8'h20, `done` pulsed in the 3rd grant cycle → `gnt` = 8'h20 for 3 cycles, `gnt_id` = 5, then `gnt` = 8'h00. `ptr` becomes 6; with `req` still 8'h20, regrant to 5 after one turnaround cycle.
- **Fairness and wrap:** `req` = 8'hFF held, `done` every grant cycle → grant order 0,1,2,…,7,0,1, each separated by one idle cycle. The wrap from 7 to 0 is verified.
- **Timeout:** `MAX_HOLD` = 4, `req` = 8'h08, `done` = 0 → `gnt` = 8'h08 for exactly 4 cycles, `timeout` = 1 for one cycle as `gnt_valid` falls. Then regrant to 3. Repeat with `done` asserted on cycle 4 → `timeout` stays 0.
- **Enable gating:** `en` = 0 with `req` = 8'h81 → no grant. `en` dropped mid-grant → current grant runs to `done`, no new grant until `en` = 1.
- **Request drop and reset mid-grant:** owner drops its `req` bit → release next cycle. Assert `rst_n` = 0 while `gnt` = 8'h04 → all outputs zero next cycle; the first grant after reset comes from a scan starting at index 0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant, voluntary release,
// request-drop release and an optional hold-limit timeout.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_gnt_id;
    logic [7:0] r_gnt;
    logic [7:0] r_hold;
    logic       r_gnt_valid;
    logic       r_timeout;

    logic [2:0] w_pick;
    logic       w_any;
    logic       w_vol_rel;
    logic       w_hold_hit;
    logic       w_release;

    // Scan from the farthest offset down so the set bit nearest to r_ptr wins.
    always_comb begin
        w_pick = r_ptr;
        w_any  = |req;
        for (int k = 7; k >= 0; k--) begin
            if (req[r_ptr + 3'(k)]) begin
                w_pick = r_ptr + 3'(k);
            end
        end
    end

    // A coincident done or request drop makes the release voluntary (no timeout pulse).
    always_comb begin
        w_vol_rel  = done | ~req[r_gnt_id];
        w_hold_hit = (MAX_HOLD != 0) && (r_hold == HOLD_LIM);
        w_release  = w_vol_rel | w_hold_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 3'd0;
            r_gnt_id    <= 3'd0;
            r_gnt       <= 8'h00;
            r_hold      <= 8'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en && w_any) begin
                        r_state     <= GRANT;
                        r_gnt_id    <= w_pick;
                        r_gnt       <= 8'h01 << w_pick;
                        r_gnt_valid <= 1'b1;
                        r_hold      <= 8'd1;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state     <= IDLE;
                        r_gnt       <= 8'h00;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_id + 3'd1;
                        r_timeout   <= w_hold_hit & ~w_vol_rel;
                    end else if (r_hold != 8'hFF) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: a cycle model predicts every registered output
// into an expected queue, plus explicit checks of grant order, timeout and gating.
module tb_rr_arbiter8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic       dbg_state;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];

    // reference model state
    bit       m_valid = 1'b0;
    bit       m_to    = 1'b0;
    bit [2:0] m_id    = 3'd0;
    bit [2:0] m_ptr   = 3'd0;
    int       m_hold  = 0;

    rr_arbiter8 #(.MAX_HOLD(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_step();
        bit vol;
        bit hit;
        bit found;
        m_to = 1'b0;
        if (!rst_n) begin
            m_valid = 1'b0; m_id = 3'd0; m_ptr = 3'd0; m_hold = 0;
        end else if (!m_valid) begin
            found = 1'b0;
            if (en) begin
                for (int i = 0; i < 8; i++) begin
                    if (!found && req[(int'(m_ptr) + i) % 8]) begin
                        found  = 1'b1;
                        m_id   = 3'((int'(m_ptr) + i) % 8);
                        m_valid = 1'b1;
                        m_hold = 1;
                    end
                end
            end
        end else begin
            vol = done || !req[m_id];
            hit = (H != 0) && (m_hold == H);
            if (vol || hit) begin
                m_valid = 1'b0;
                m_ptr   = m_id + 3'd1;
                m_to    = hit && !vol;
            end else begin
                m_hold = (m_hold < 255) ? m_hold + 1 : 255;
            end
        end
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic cyc(input logic r, input logic e, input logic [7:0] q, input logic d);
        logic [12:0] exp_v;
        logic [12:0] obs_v;
        rst_n = r; en = e; req = q; done = d;
        model_step();
        exp_q.push_back({m_to, m_valid, m_id, (m_valid ? (8'h01 << m_id) : 8'h00)});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        obs_v = {timeout, gnt_valid, gnt_id, gnt};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL cycle obs={to,v,id,gnt}=%h exp=%h", obs_v, exp_v);
        end
        checks++;
        assert (($countones(gnt) <= 1) === 1'b1) else begin
            errors++;
            $error("FAIL onehot obs=%h exp=at_most_one_bit", gnt);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [2:0] order[$];
        rst_n = 1'b0; en = 1'b1; req = 8'hFF; done = 1'b0;

        // reset held with all requests high
        cyc(0, 1, 8'hFF, 0); chk("rst_gnt", gnt, 8'h00); chk("rst_valid", {7'd0, gnt_valid}, 8'h00);
        cyc(0, 1, 8'hFF, 0); chk("rst_id", {5'd0, gnt_id}, 8'h00);
        cyc(1, 1, 8'hFF, 0); chk("post_rst_gnt", gnt, 8'h01);

        // single requester 5, done in the third grant cycle
        cyc(0, 1, 8'h20, 0);
        cyc(1, 1, 8'h20, 0); chk("single_g1", gnt, 8'h20); chk("single_id", {5'd0, gnt_id}, 8'd5);
        cyc(1, 1, 8'h20, 0); chk("single_g2", gnt, 8'h20);
        cyc(1, 1, 8'h20, 0); chk("single_g3", gnt, 8'h20);
        cyc(1, 1, 8'h20, 1); chk("single_rel", gnt, 8'h00);
        cyc(1, 1, 8'h20, 0); chk("single_regrant", gnt, 8'h20);
        cyc(1, 1, 8'h60, 1); chk("single_rel2", gnt, 8'h00);
        cyc(1, 1, 8'h60, 0); chk("ptr_after_5", {5'd0, gnt_id}, 8'd6);

        // fairness and wrap: all requesting, done every cycle
        cyc(0, 1, 8'hFF, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 8'hFF, 1);
            if (gnt_valid) order.push_back(gnt_id);
        end
        chk("fair_count", 8'(order.size()), 8'd10);
        for (int i = 0; i < 10 && i < order.size(); i++) begin
            chk("fair_order", {5'd0, order[i]}, 8'(i % 8));
        end

        // hold-limit timeout, then regrant, then done coincident with the limit
        cyc(0, 1, 8'h08, 0);
        for (int i = 0; i < H; i++) begin
            cyc(1, 1, 8'h08, 0); chk("to_hold", gnt, 8'h08);
        end
        cyc(1, 1, 8'h08, 0); chk("to_gnt_off", gnt, 8'h00); chk("to_pulse", {7'd0, timeout}, 8'h01);
        cyc(1, 1, 8'h08, 0); chk("to_regrant", gnt, 8'h08); chk("to_pulse_off", {7'd0, timeout}, 8'h00);
        for (int i = 1; i < H; i++) cyc(1, 1, 8'h08, 0);
        cyc(1, 1, 8'h08, 1); chk("to_vol_gnt", gnt, 8'h00); chk("to_vol_nopulse", {7'd0, timeout}, 8'h00);

        // enable gating
        cyc(0, 1, 8'h81, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 8'h81, 0); chk("en_off", gnt, 8'h00);
        end
        cyc(1, 1, 8'h81, 0); chk("en_on", gnt, 8'h01);
        cyc(1, 0, 8'h81, 0); chk("en_drop_keep", gnt, 8'h01);
        cyc(1, 0, 8'h81, 1); chk("en_drop_rel", gnt, 8'h00);
        cyc(1, 0, 8'h81, 0); chk("en_drop_idle", gnt, 8'h00);
        cyc(1, 0, 8'h81, 0);
        cyc(1, 1, 8'h81, 0); chk("en_resume", gnt, 8'h80);

        // request drop, then reset mid-grant
        cyc(0, 1, 8'h04, 0);
        cyc(1, 1, 8'h04, 0); chk("drop_grant", gnt, 8'h04);
        cyc(1, 1, 8'h00, 0); chk("drop_rel", gnt, 8'h00);
        cyc(1, 1, 8'h04, 0); chk("mid_grant", gnt, 8'h04);
        cyc(0, 1, 8'h04, 1); chk("mid_rst_gnt", gnt, 8'h00); chk("mid_rst_id", {5'd0, gnt_id}, 8'h00);
        chk("mid_rst_to", {7'd0, timeout}, 8'h00);
        cyc(1, 1, 8'h0A, 0); chk("mid_rst_scan0", gnt, 8'h02);

        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL queue_drain obs=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
